// File: rtl/core_pkg.sv
// Shared core definitions: ALU control codes, M-extension sequencer states, default width.
package core_pkg;

  localparam int unsigned XlenDefault = 32;

  // alu_ctl codes shared by the decoder, ALU and M-extension sequencer
  localparam logic [4:0] AluAdd    = 5'b00000;
  localparam logic [4:0] AluMul    = 5'b00010;
  localparam logic [4:0] AluMulh   = 5'b00011;
  localparam logic [4:0] AluMulhsu = 5'b00100;
  localparam logic [4:0] AluMulhu  = 5'b00101;
  localparam logic [4:0] AluDiv    = 5'b00110;
  localparam logic [4:0] AluDivu   = 5'b00111;
  localparam logic [4:0] AluRem    = 5'b01000;
  localparam logic [4:0] AluRemu   = 5'b01001;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } md_state_e;

  // M-codes form one contiguous range
  function automatic logic is_mcode(input logic [4:0] ctl);
    return (ctl >= AluMul) && (ctl <= AluRemu);
  endfunction

  function automatic logic is_div_code(input logic [4:0] ctl);
    return (ctl >= AluDiv) && (ctl <= AluRemu);
  endfunction

endpackage

// File: rtl/md_div_core.sv
// Restoring divider datapath: one quotient bit per step, unsigned operands.
// load captures the operands; load and step together perform the first step from the
// freshly loaded values so XLEN steps take XLEN cycles.
module md_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r,
  output logic            last
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic [XLEN-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] src_q, src_r, src_d;
  logic [XLEN:0]   shifted, diff;

  // Shift-subtract step on either the loaded operands or the running registers
  always_comb begin
    src_r   = load ? '0 : r_q;
    src_q   = load ? dividend : q_q;
    src_d   = load ? divisor : d_q;
    shifted = {src_r, src_q[XLEN-1]};
    // MSB of diff set means the trial subtraction went negative
    diff    = shifted - {1'b0, src_d};
    q_d     = q_q;
    r_d     = r_q;
    d_d     = src_d;
    cnt_d   = cnt_q;
    if (load) begin
      q_d   = dividend;
      r_d   = '0;
      cnt_d = '0;
    end
    if (step) begin
      if (!diff[XLEN]) begin
        r_d = diff[XLEN-1:0];
        q_d = {src_q[XLEN-2:0], 1'b1};
      end else begin
        r_d = shifted[XLEN-1:0];
        q_d = {src_q[XLEN-2:0], 1'b0};
      end
      if (!load) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  // Counter is cleared on the step that loads, so the final step sees XLEN-2
  assign last = (cnt_q == CntW'(XLEN - 2));

endmodule

// File: rtl/md_seq.sv
// Multi-cycle M-extension sequencer: registered multiply, restoring divide, pipeline stall.
module md_seq
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e       state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [4:0]      ctl_q, ctl_d;
  logic            done_q, done_d;
  logic            first_q, first_d;

  logic accept;
  assign accept = start && is_mcode(alu_ctl) && !flush;

  // Multiply: sign/zero-extend to 2*XLEN bits; product modulo 2^(2*XLEN) is exact
  logic            sign_a, sign_b;
  logic [2*XLEN-1:0] a_wide, b_wide, prod;
  logic [XLEN-1:0] mul_res;
  assign sign_a  = (ctl_q == AluMulh || ctl_q == AluMulhsu) && a_q[XLEN-1];
  assign sign_b  = (ctl_q == AluMulh) && b_q[XLEN-1];
  assign a_wide  = {{XLEN{sign_a}}, a_q};
  assign b_wide  = {{XLEN{sign_b}}, b_q};
  assign prod    = a_wide * b_wide;
  assign mul_res = (ctl_q == AluMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Divide operand conditioning and special cases
  logic            div_signed, want_rem, a_neg, b_neg, div_zero, div_ovf, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res, div_q, div_r, fix_res;
  logic            div_load, div_step, div_last;
  assign div_signed  = (ctl_q == AluDiv) || (ctl_q == AluRem);
  assign want_rem    = (ctl_q == AluRem) || (ctl_q == AluRemu);
  assign a_neg       = div_signed && a_q[XLEN-1];
  assign b_neg       = div_signed && b_q[XLEN-1];
  assign abs_a       = a_neg ? -a_q : a_q;
  assign abs_b       = b_neg ? -b_q : b_q;
  assign div_zero    = (b_q == '0);
  assign div_ovf     = div_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
  assign special     = div_zero || div_ovf;
  assign special_res = div_zero ? (want_rem ? a_q : '1) : (want_rem ? '0 : a_q);
  assign fix_res     = want_rem ? (a_neg ? -div_r : div_r)
                                : ((a_neg ^ b_neg) ? -div_q : div_q);

  assign div_load = (state_q == StDiv) && first_q && !special;
  assign div_step = (state_q == StDiv) && !(first_q && special);

  md_div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (abs_a),
    .divisor  (abs_b),
    .q        (div_q),
    .r        (div_r),
    .last     (div_last)
  );

  // Next-state, operand latch and registered result/done
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    result_d = result_q;
    done_d   = 1'b0;
    first_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = op_a;
          b_d     = op_b;
          ctl_d   = alu_ctl;
          state_d = is_div_code(alu_ctl) ? StDiv : StMul;
          first_d = is_div_code(alu_ctl);
        end
      end
      StMul: begin
        result_d = mul_res;
        done_d   = 1'b1;
        state_d  = StDone;
      end
      StDiv: begin
        if (first_q && special) begin
          result_d = special_res;
          done_d   = 1'b1;
          state_d  = StDone;
        end else if (!first_q && div_last) begin
          state_d = StFix;
        end
      end
      StFix: begin
        result_d = fix_res;
        done_d   = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Redirect kills whatever is in flight
    if (flush) begin
      state_d = StIdle;
      done_d  = 1'b0;
      first_d = 1'b0;
    end
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      result_q <= result_d;
      done_q   <= done_d;
      first_q  <= first_d;
    end
  end

  assign stall  = ((state_q == StIdle) && accept) ||
                  (state_q inside {StMul, StDiv, StFix});
  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_md_seq.sv
// Directed bench for md_seq: latency, stall length and result of each M-op plus flush/reset.
module tb_md_seq;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [4:0]  alu_ctl;
  logic [31:0] op_a, op_b;
  logic        stall, busy, done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  md_seq #(
    .XLEN(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .alu_ctl (alu_ctl),
    .op_a    (op_a),
    .op_b    (op_b),
    .flush   (flush),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge (cycle 0) and follow it to done
  task automatic run_op(input string tag, input logic [4:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int cyc;
    int stalls;
    bit seen;
    @(negedge clk);
    start   = 1'b1;
    alu_ctl = ctl;
    op_a    = a;
    op_b    = b;
    #1;
    stalls = stall ? 1 : 0;
    @(negedge clk);
    start   = 1'b0;
    alu_ctl = AluAdd;
    cyc     = 1;
    seen    = 1'b0;
    while (cyc < 64 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (stall) stalls++;
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_lat"}, cyc, exp_lat);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_stall"}, stalls, exp_lat);
    @(negedge clk);
    check({tag, "_done_once"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    bit saw_done;
    rst     = 1'b1;
    start   = 1'b0;
    flush   = 1'b0;
    alu_ctl = AluAdd;
    op_a    = '0;
    op_b    = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", {31'b0, stall}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_result", result, 0);
    rst = 1'b0;

    run_op("mul", AluMul, 32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFEB);
    run_op("mulhu", AluMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
    run_op("mulh", AluMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0000);
    run_op("mulhsu", AluMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);
    run_op("div", AluDiv, 32'hFFFF_FFEC, 32'd3, 34, 32'hFFFF_FFFA);
    run_op("rem", AluRem, 32'hFFFF_FFEC, 32'd3, 34, 32'hFFFF_FFFE);
    run_op("divu", AluDivu, 32'd20, 32'd3, 34, 32'd6);
    run_op("remu", AluRemu, 32'd100, 32'd7, 34, 32'd2);
    run_op("div0", AluDiv, 32'd5, 32'd0, 2, 32'hFFFF_FFFF);
    run_op("rem0", AluRem, 32'd5, 32'd0, 2, 32'd5);
    run_op("div_ovf", AluDiv, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'h8000_0000);
    run_op("rem_ovf", AluRem, 32'h8000_0000, 32'hFFFF_FFFF, 2, 32'd0);

    // Flush on cycle 10 of a divide
    @(negedge clk);
    start   = 1'b1;
    alu_ctl = AluDiv;
    op_a    = 32'hFFFF_FFEC;
    op_b    = 32'd3;
    @(negedge clk);
    start   = 1'b0;
    alu_ctl = AluAdd;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_stall", {31'b0, stall}, 0);
    check("flush_busy", {31'b0, busy}, 0);
    saw_done = done;
    repeat (30) begin
      @(negedge clk);
      saw_done |= done;
    end
    check("flush_no_done", {31'b0, saw_done}, 0);
    run_op("mul_after_flush", AluMul, 32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFEB);

    // Non-M code is ignored
    @(negedge clk);
    start   = 1'b1;
    alu_ctl = AluAdd;
    op_a    = 32'd1;
    op_b    = 32'd2;
    #1;
    check("add_stall", {31'b0, stall}, 0);
    @(negedge clk);
    check("add_busy", {31'b0, busy}, 0);
    check("add_stall2", {31'b0, stall}, 0);
    start = 1'b0;

    // Reset mid-divide
    @(negedge clk);
    start   = 1'b1;
    alu_ctl = AluDivu;
    op_a    = 32'd1000;
    op_b    = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", {31'b0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_stall", {31'b0, stall}, 0);
    check("rst2_busy", {31'b0, busy}, 0);
    check("rst2_done", {31'b0, done}, 0);
    check("rst2_result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
